// File: rtl/point_rx_pkg.sv
// Shared defaults and helpers for the point-link receive buffer.
// Used by point_rx_buffer and point_rx_ram.
package point_rx_pkg;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_DEPTH        = 16;
    localparam int DEF_AFULL_MARGIN = 2;

    // Address bits plus one wrap bit, so full and empty can be told apart.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/point_rx_ram.sv
// Storage for the receive buffer: DEPTH x WIDTH words.
// One synchronous write port and one asynchronous (show-ahead) read port.
module point_rx_ram
    import point_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/point_rx_buffer.sv
// Receive-side elastic buffer behind a point_slave_io endpoint, with a registered credit.
// Optional running checksum of accepted words when POINT_RX_CHECKSUM_EN is defined.
module point_rx_buffer
    import point_rx_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int AFULL_MARGIN = DEF_AFULL_MARGIN
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          link_data,
    input  logic                      link_valid,
    output logic                      link_resp,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ptr_w(DEPTH)-1:0]   level,
    output logic                      overflow,
    input  logic                      clr
`ifdef POINT_RX_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]          checksum
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    localparam logic [PW-1:0] DEPTH_L  = PW'(DEPTH);
    localparam logic [PW-1:0] MARGIN_L = PW'(AFULL_MARGIN);
    localparam logic [PW-1:0] ONE_L    = PW'(1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    free_cnt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             drop;
    logic [WIDTH-1:0] ram_rdata;

    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = link_valid && (!full || pop);
    assign drop      = link_valid && full && !pop;

    // Mask the raw RAM word so out_data reads 0 whenever nothing is presented.
    assign out_data = out_valid ? ram_rdata : '0;

    point_rx_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (link_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_L;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_L;
            end
        end
    end

    // Drop has priority over clear so a loss in the clearing cycle is not hidden.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr) begin
            overflow <= 1'b0;
        end
    end

    // Credit is registered from the current occupancy, so it trails level by one edge;
    // AFULL_MARGIN absorbs that lag plus the endpoint round trip.
    assign free_cnt = DEPTH_L - level;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            link_resp <= 1'b1;
        end else begin
            link_resp <= (free_cnt >= MARGIN_L);
        end
    end

`ifdef POINT_RX_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (clr) begin
            checksum <= push ? link_data : '0;
        end else if (push) begin
            checksum <= checksum + link_data;
        end
    end
`endif

endmodule
